// File: rtl/free_list_ctrl.sv
// Circular physical-register free list for a 3-wide rename stage: grants up to
// three free tags per cycle, reclaims up to three retired Told tags, and refills on branch recovery.

module free_list_ctrl_chk #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input logic             clock,
    input logic             reset,
    input logic [CNT_W-1:0] count,
    input logic [1:0]       granted,
    input logic [1:0]       freed
);

    // Frees must never push the pool beyond its capacity.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((int'(count) + int'(freed) - int'(granted)) <= DEPTH);
        end
    end

endmodule

module free_list_ctrl #(
    parameter int PR_NUM = 64,
    parameter int AR_NUM = 32,
    parameter int PR     = $clog2(PR_NUM),
    parameter int DEPTH  = PR_NUM - AR_NUM
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         BPRecoverEN,
    input  logic [2:0]                   alloc_req,
    output logic [2:0][PR-1:0]           alloc_pr,
    output logic [2:0]                   alloc_valid,
    input  logic [2:0]                   free_en,
    input  logic [2:0][PR-1:0]           free_pr,
    output logic [$clog2(DEPTH+1)-1:0]   free_count,
    output logic [1:0]                   avail_num
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W+1:0] DEPTH_PTR = (PTR_W + 2)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PR-1:0]             entry_r [DEPTH];
    logic [PTR_W-1:0]          head_r;
    logic [PTR_W-1:0]          tail_r;
    logic [CNT_W-1:0]          count_r;

    logic [2:0][1:0]           rank_s;
    logic [2:0][1:0]           free_rank_s;
    logic [2:0][PTR_W-1:0]     rd_idx_s;
    logic [2:0][PTR_W-1:0]     wr_idx_s;
    logic [1:0]                granted_s;
    logic [1:0]                granted_eff_s;
    logic [1:0]                freed_s;
    logic [PTR_W-1:0]          head_next_s;
    logic [PTR_W-1:0]          tail_next_s;
    logic [CNT_W-1:0]          count_next_s;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Pointer advance with explicit modulo-DEPTH wrap (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input logic [1:0] inc);
        logic [PTR_W+1:0] sum;
        sum = {2'b00, ptr} + {{PTR_W{1'b0}}, inc};
        if (sum >= DEPTH_PTR) begin
            sum = sum - DEPTH_PTR;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Slot ranks and read/write indices for in-order grants and compacted frees.
    always_comb begin
        rank_s         = '0;
        free_rank_s    = '0;
        rank_s[1]      = {1'b0, alloc_req[0]};
        rank_s[2]      = popcount3({1'b0, alloc_req[1:0]});
        free_rank_s[1] = {1'b0, free_en[0]};
        free_rank_s[2] = popcount3({1'b0, free_en[1:0]});
        for (int i = 0; i < 3; i++) begin
            rd_idx_s[i]    = wrap_add(head_r, rank_s[i]);
            wr_idx_s[i]    = wrap_add(tail_r, free_rank_s[i]);
            alloc_pr[i]    = entry_r[rd_idx_s[i]];
            alloc_valid[i] = alloc_req[i] && ({{(CNT_W-2){1'b0}}, rank_s[i]} < count_r);
        end
    end

    // Next-state pointers and count; recovery discards this cycle's grants and refills the pool.
    always_comb begin
        granted_s     = popcount3(alloc_valid);
        freed_s       = popcount3(free_en);
        tail_next_s   = wrap_add(tail_r, freed_s);
        granted_eff_s = granted_s;
        head_next_s   = head_r;
        count_next_s  = count_r;
        if (BPRecoverEN) begin
            granted_eff_s = 2'd0;
            head_next_s   = tail_next_s;
            count_next_s  = DEPTH_CNT;
        end else begin
            head_next_s  = wrap_add(head_r, granted_s);
            count_next_s = count_r - {{(CNT_W-2){1'b0}}, granted_s}
                                   + {{(CNT_W-2){1'b0}}, freed_s};
        end
    end

    // Free-list storage and pointer registers; reset restores the identity pool AR_NUM..PR_NUM-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= PR'(AR_NUM + i);
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= DEPTH_CNT;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (free_en[i]) begin
                    entry_r[wr_idx_s[i]] <= free_pr[i];
                end
            end
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

    // Availability hint saturates at the rename width.
    always_comb begin
        free_count = count_r;
        if (count_r >= CNT_W'(3)) begin
            avail_num = 2'd3;
        end else begin
            avail_num = count_r[1:0];
        end
    end

    free_list_ctrl_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clock   (clock),
        .reset   (reset),
        .count   (count_r),
        .granted (granted_eff_s),
        .freed   (freed_s)
    );

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: a ring model predicts each cycle's grants and
// counts; directed scenarios add fixed-value checks for reset, wrap, empty and recovery.

module tb_free_list_ctrl;

    typedef struct packed {
        logic [2:0]      v;
        logic [2:0][5:0] pr;
        logic [5:0]      fc;
        logic [1:0]      av;
    } exp_t;

    logic            clock;
    logic            reset;
    logic            BPRecoverEN;
    logic [2:0]      alloc_req;
    logic [2:0][5:0] alloc_pr;
    logic [2:0]      alloc_valid;
    logic [2:0]      free_en;
    logic [2:0][5:0] free_pr;
    logic [5:0]      free_count;
    logic [1:0]      avail_num;

    int   passed = 0;
    int   total  = 0;
    exp_t exp_q[$];

    int m_entry[32];
    int m_head, m_tail, m_count;

    free_list_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .BPRecoverEN (BPRecoverEN),
        .alloc_req   (alloc_req),
        .alloc_pr    (alloc_pr),
        .alloc_valid (alloc_valid),
        .free_en     (free_en),
        .free_pr     (free_pr),
        .free_count  (free_count),
        .avail_num   (avail_num)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int pc3(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 32; i++) m_entry[i] = 32 + i;
        m_head  = 0;
        m_tail  = 0;
        m_count = 32;
    endfunction

    function automatic exp_t model_eval(input logic [2:0] req);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            e.pr[i] = 6'(m_entry[(m_head + n) % 32]);
            e.v[i]  = req[i] && (n < m_count);
            if (req[i]) n++;
        end
        e.fc = 6'(m_count);
        e.av = (m_count >= 3) ? 2'd3 : 2'(m_count);
        return e;
    endfunction

    function automatic void model_update(input logic [2:0] req, input logic [2:0] fen,
                                         input logic [2:0][5:0] fpr, input logic rec, input logic rst);
        int g, f;
        if (rst) begin
            model_init();
        end else begin
            g = pc3(req);
            if (g > m_count) g = m_count;
            f = 0;
            for (int i = 0; i < 3; i++) begin
                if (fen[i]) begin
                    m_entry[m_tail] = int'(fpr[i]);
                    m_tail = (m_tail + 1) % 32;
                    f++;
                end
            end
            if (rec) begin
                m_head  = m_tail;
                m_count = 32;
            end else begin
                m_head  = (m_head + g) % 32;
                m_count = m_count - g + f;
            end
        end
    endfunction

    // Drive one cycle of stimulus (called just after a rising edge) and queue its prediction.
    task automatic drive(input logic [2:0] req, input logic [2:0] fen, input logic [2:0][5:0] fpr,
                         input logic rec, input logic rst);
        alloc_req   = req;
        free_en     = fen;
        free_pr     = fpr;
        BPRecoverEN = rec;
        reset       = rst;
        exp_q.push_back(model_eval(req));
        model_update(req, fen, fpr, rec, rst);
    endtask

    task automatic sample(output exp_t got, output exp_t want);
        @(negedge clock);
        got.v  = alloc_valid;
        got.pr = alloc_pr;
        got.fc = free_count;
        got.av = avail_num;
        if (exp_q.size() == 0) want = '1;
        else                   want = exp_q.pop_front();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        BPRecoverEN = 1'b0;
        alloc_req   = 3'b000;
        free_en     = 3'b000;
        free_pr     = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_init();
        exp_q.delete();
    endtask

    task automatic test_reset();
        exp_t g, w;
        do_reset();
        drive(3'b000, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_reset: got %h expected %h", g, w); else passed++;
        total++;
        if (g.fc !== 6'd32 || g.av !== 2'd3 || g.v !== 3'b000)
            $display("FAIL reset_state: got fc=%0d av=%0d v=%b expected fc=32 av=3 v=000", g.fc, g.av, g.v);
        else passed++;
    endtask

    task automatic test_alloc3();
        exp_t g, w;
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_alloc3: got %h expected %h", g, w); else passed++;
        total++;
        if (g.v !== 3'b111 || g.pr !== {6'd34, 6'd33, 6'd32})
            $display("FAIL alloc3_tags: got v=%b pr=%h expected v=111 pr=%h", g.v, g.pr, {6'd34, 6'd33, 6'd32});
        else passed++;
        drive(3'b000, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g.fc !== 6'd29) $display("FAIL alloc3_count: got %0d expected 29", g.fc); else passed++;
    endtask

    task automatic test_sparse();
        exp_t g, w;
        do_reset();
        drive(3'b101, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_sparse: got %h expected %h", g, w); else passed++;
        total++;
        if (g.v !== 3'b101 || g.pr[0] !== 6'd32 || g.pr[2] !== 6'd33)
            $display("FAIL sparse_tags: got v=%b pr0=%0d pr2=%0d expected v=101 pr0=32 pr2=33", g.v, g.pr[0], g.pr[2]);
        else passed++;
        drive(3'b001, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.fc !== 6'd30 || g.pr[0] !== 6'd34)
            $display("FAIL sparse_head: got fc=%0d pr0=%0d expected fc=30 pr0=34", g.fc, g.pr[0]);
        else passed++;
    endtask

    task automatic test_drain_empty();
        exp_t g, w;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive((c < 10) ? 3'b111 : 3'b001, 3'b000, '0, 1'b0, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_drain c%0d: got %h expected %h", c, g, w); else passed++;
        end
        drive(3'b111, 3'b011, {6'd0, 6'd7, 6'd5}, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.v !== 3'b001 || g.pr[0] !== 6'd63 || g.fc !== 6'd1)
            $display("FAIL count1_grant: got v=%b pr0=%0d fc=%0d expected v=001 pr0=63 fc=1", g.v, g.pr[0], g.fc);
        else passed++;
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.fc !== 6'd2 || g.v !== 3'b011 || g.pr[0] !== 6'd5 || g.pr[1] !== 6'd7)
            $display("FAIL freed_next: got fc=%0d v=%b pr=%h expected fc=2 v=011 pr0=5 pr1=7", g.fc, g.v, g.pr);
        else passed++;
        drive(3'b111, 3'b001, {6'd0, 6'd0, 6'd9}, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.v !== 3'b000 || g.fc !== 6'd0 || g.av !== 2'd0)
            $display("FAIL empty: got v=%b fc=%0d av=%0d expected v=000 fc=0 av=0", g.v, g.fc, g.av);
        else passed++;
        drive(3'b001, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_after_empty: got %h expected %h", g, w); else passed++;
        total++;
        if (g.v !== 3'b001 || g.pr[0] !== 6'd9)
            $display("FAIL free_while_empty: got v=%b pr0=%0d expected v=001 pr0=9", g.v, g.pr[0]);
        else passed++;
    endtask

    task automatic test_wrap();
        exp_t g, w;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive((c < 10) ? 3'b111 : 3'b001, 3'b000, '0, 1'b0, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_wrap_alloc c%0d: got %h expected %h", c, g, w); else passed++;
        end
        for (int c = 0; c < 11; c++) begin
            drive(3'b000, (c < 10) ? 3'b111 : 3'b001,
                  {6'(3 * c + 2), 6'(3 * c + 1), 6'(3 * c)}, 1'b0, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_wrap_free c%0d: got %h expected %h", c, g, w); else passed++;
        end
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_wrap_cross: got %h expected %h", g, w); else passed++;
        drive(3'b000, 3'b111, {6'd52, 6'd51, 6'd50}, 1'b0, 1'b0);
        sample(g, w);
        for (int c = 0; c < 10; c++) begin
            drive((c < 9) ? 3'b111 : 3'b011, 3'b000, '0, 1'b0, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_wrap_adv c%0d: got %h expected %h", c, g, w); else passed++;
        end
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.v !== 3'b111 || g.pr !== {6'd52, 6'd51, 6'd50})
            $display("FAIL wrap_order: got v=%b pr=%h expected v=111 pr=%h", g.v, g.pr, {6'd52, 6'd51, 6'd50});
        else passed++;
    endtask

    task automatic test_recovery();
        exp_t g, w;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive((c < 3) ? 3'b111 : 3'b001, 3'b000, '0, 1'b0, 1'b0);
            sample(g, w);
        end
        drive(3'b000, 3'b111, {6'd3, 6'd2, 6'd1}, 1'b0, 1'b0);
        sample(g, w);
        drive(3'b000, 3'b001, {6'd0, 6'd0, 6'd4}, 1'b0, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_pre_recover: got %h expected %h", g, w); else passed++;
        drive(3'b111, 3'b000, '0, 1'b1, 1'b0);
        sample(g, w);
        total++; if (g !== w) $display("FAIL sb_recover: got %h expected %h", g, w); else passed++;
        BPRecoverEN = 1'b0;
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.fc !== 6'd32 || g.v !== 3'b111 || g.pr !== {6'd38, 6'd37, 6'd36})
            $display("FAIL recover_state: got fc=%0d v=%b pr=%h expected fc=32 v=111 pr=%h",
                     g.fc, g.v, g.pr, {6'd38, 6'd37, 6'd36});
        else passed++;
        for (int c = 0; c < 9; c++) begin
            drive((c < 8) ? 3'b111 : 3'b001, 3'b000, '0, 1'b0, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_recover_drain c%0d: got %h expected %h", c, g, w); else passed++;
        end
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.pr !== {6'd3, 6'd2, 6'd1})
            $display("FAIL recover_reclaimed: got pr=%h expected %h", g.pr, {6'd3, 6'd2, 6'd1});
        else passed++;
    endtask

    task automatic test_reset_vs_recover();
        exp_t g, w;
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        drive(3'b111, 3'b011, {6'd0, 6'd11, 6'd10}, 1'b0, 1'b0);
        sample(g, w);
        drive(3'b111, 3'b111, {6'd14, 6'd13, 6'd12}, 1'b1, 1'b1);
        sample(g, w);
        BPRecoverEN = 1'b0;
        drive(3'b111, 3'b000, '0, 1'b0, 1'b0);
        sample(g, w);
        total++;
        if (g.fc !== 6'd32 || g.pr !== {6'd34, 6'd33, 6'd32})
            $display("FAIL reset_wins: got fc=%0d pr=%h expected fc=32 pr=%h", g.fc, g.pr, {6'd34, 6'd33, 6'd32});
        else passed++;
        total++; if (g !== w) $display("FAIL sb_reset_wins: got %h expected %h", g, w); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t       g, w;
        logic [2:0] req, fen;
        logic       rec;
        int         gr, room;
        for (int c = 0; c < 300; c++) begin
            req = 3'($urandom_range(0, 7));
            rec = ($urandom_range(0, 15) == 0);
            gr  = pc3(req);
            if (gr > m_count) gr = m_count;
            room = 32 - m_count + (rec ? 0 : gr);
            fen  = 3'($urandom_range(0, 7));
            for (int b = 2; b >= 0; b--) begin
                if (pc3(fen) > room) fen[b] = 1'b0;
            end
            drive(req, fen, {6'($urandom), 6'($urandom), 6'($urandom)}, rec, 1'b0);
            sample(g, w);
            total++; if (g !== w) $display("FAIL sb_random c%0d: got %h expected %h", c, g, w); else passed++;
        end
        BPRecoverEN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alloc3();
        test_sparse();
        test_drain_empty();
        test_wrap();
        test_recovery();
        test_reset_vs_recover();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
